shift_arbiter: RTL and testbench
================================

Name: shift_arbiter

Overview:
- Shares the single combinational right barrel shifter (5-stage shift network, SRL operation code 3'b101) between two requesters: requester 0 is the EX-stage ALU shift path, requester 1 is the multi-cycle multiply/divide unit.
- Round-robin arbitration with valid/ready handshakes on both inputs and on the output.
- Adds SLL by bit-reversing operand and result around the right shifter.
- One registered result slot; one-cycle latency from accept to result.

Parameters:
- WIDTH, 32, datapath width; the shifter is fixed at 32, so only 32 is legal.
- OP_SRL, 3'b101, logical right shift code; matches the shifter's SRL select.
- OP_SLL, 3'b100, logical left shift code.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_data  in  32  operand from requester 0.
- req0_shamt  in  5  shift amount from requester 0.
- req0_op  in  3  operation from requester 0.
- req1_valid, req1_ready, req1_data, req1_shamt, req1_op: same as requester 0, for requester 1.
- res_valid  out  1  result slot full.
- res_ready  in  1  consumer takes the result.
- res_data  out  32  shift result.
- res_id  out  1  requester that owns the result.
- res_err  out  1  request carried an unsupported op.
- sh_data  out  32  operand to the barrel shifter.
- sh_sel  out  5  shift amount to the barrel shifter.
- sh_signal  out  3  op select to the barrel shifter; always driven to OP_SRL.
- sh_result  in  32  barrel shifter output (combinational).

Behaviour:
- One clock and one reset: clk, with rst synchronous and active-high. rst is sampled on the clk rising edge only.
- Reset values:
  - res_valid=0, res_data=0, res_id=0, res_err=0.
  - last_grant=1, so requester 0 wins the first contested cycle.
- State machine has two states:
  - EMPTY: res_valid=0.
  - FULL: res_valid=1.
- slot_free = EMPTY, or (FULL and res_ready). Draining and refilling in the same cycle gives full throughput.
- Grant is combinational:
  - If only one req valid, grant that requester.
  - If both valid, grant the one not equal to last_grant.
  - reqN_ready = slot_free and grant==N. At most one ready is high per cycle.
  - A ready is never asserted without the matching valid.
- Accept = the granted reqN_valid and reqN_ready. On accept:
  - last_grant <= N.
  - res_id <= N.
  - State goes to FULL.
- Shifter drive (combinational from the granted request):
  - sh_sel = shamt. sh_signal = OP_SRL.
  - For op OP_SRL: sh_data = data, and res_data <= sh_result.
  - For op OP_SLL: sh_data = bit-reverse(data), and res_data <= bit-reverse(sh_result).
  - For any other op: res_data <= data unchanged and res_err <= 1. The request is still accepted and completed.
  - res_err <= 0 for legal ops.
- Hold rules:
  - FULL without res_ready: res_data, res_id and res_err are held stable; both readys are 0.
  - FULL with res_ready and no accept: state goes to EMPTY; res_data keeps its last value (don't-care).
  - No valid input: sh_* outputs are don't-care. Implement them as the requester 0 fields.
- shamt=0 returns the operand unchanged for both SRL and SLL. shamt=31 leaves a single surviving bit.
- Requesters must hold data, shamt and op stable while valid and not ready. The arbiter does not latch them before accept.
- Reset mid-operation: a held result is discarded, res_valid goes to 0 on the next edge, and last_grant returns to 1. A request that is valid during the reset cycle is not accepted (readys are forced to 0 while rst=1).
- A requester dropping valid before ready gets no acceptance and leaves no state change.

Test Plan:
- Reset then single request: req0 SRL data=32'h8000_0000, shamt=4, res_ready=1 -> next cycle res_valid=1, res_data=32'h0800_0000, res_id=0, res_err=0.
- SLL path: req1 data=32'h0000_00F1, shamt=8 -> res_data=32'h0000_F100, res_id=1. shamt=0 -> res_data=32'h0000_00F1.
- Contention: both valid every cycle, res_ready=1 -> grants alternate 0,1,0,1 starting with 0. Results arrive back-to-back at one per cycle, res_id alternating.
- Backpressure: res_ready=0 with the slot full -> req0_ready=req1_ready=0 and res_data stable for 5 cycles. res_ready=1 with both requests valid -> drain and accept in the same cycle.
- Illegal op: req0 op=3'b010, data=32'h1234_5678 -> res_data=32'h1234_5678, res_err=1. The next legal request clears res_err.
- Reset mid-hold: slot full with res_ready=0, assert rst for one cycle -> res_valid=0. After release, a contested request grants requester 0.

Source files
------------

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one right barrel shifter between two requesters.
// SLL is built by bit-reversing the operand and result around the shifter.
module shift_arbiter #(
    parameter int         WIDTH  = 32,
    parameter logic [2:0] OP_SRL = 3'b101,
    parameter logic [2:0] OP_SLL = 3'b100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [4:0]       req0_shamt,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [4:0]       req1_shamt,
    input  logic [2:0]       req1_op,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             res_err,
    output logic [WIDTH-1:0] sh_data,
    output logic [4:0]       sh_sel,
    output logic [2:0]       sh_signal,
    input  logic [WIDTH-1:0] sh_result
);

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    state_t state, state_next;

    logic             last_grant;
    logic             grant;
    logic             slot_free;
    logic             accept;
    logic [WIDTH-1:0] sel_data;
    logic [4:0]       sel_shamt;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] res_next;
    logic             err_next;

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    // With no request pending, grant falls to requester 0 so sh_* follow it.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end
    end

    assign slot_free  = (state == EMPTY) || res_ready;
    assign req0_ready = !rst && slot_free && req0_valid && !grant;
    assign req1_ready = !rst && slot_free && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;
    assign res_valid  = (state == FULL);

    assign sel_data  = grant ? req1_data : req0_data;
    assign sel_shamt = grant ? req1_shamt : req0_shamt;
    assign sel_op    = grant ? req1_op : req0_op;

    assign sh_sel    = sel_shamt;
    assign sh_signal = OP_SRL;
    assign sh_data   = (sel_op == OP_SLL) ? bit_rev(sel_data) : sel_data;

    always_comb begin
        res_next = sel_data;
        err_next = 1'b1;
        unique case (sel_op)
            OP_SRL: begin
                res_next = sh_result;
                err_next = 1'b0;
            end
            OP_SLL: begin
                res_next = bit_rev(sh_result);
                err_next = 1'b0;
            end
            default: begin
                res_next = sel_data;
                err_next = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (accept) begin
                    state_next = FULL;
                end else if (res_ready) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            res_data   <= '0;
            res_id     <= 1'b0;
            res_err    <= 1'b0;
        end else if (accept) begin
            last_grant <= grant;
            res_data   <= res_next;
            res_id     <= grant;
            res_err    <= err_next;
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: a behavioural model checked every cycle,
// plus literal expectations on the listed scenarios.
module tb_shift_arbiter;

    localparam logic [2:0] SRL = 3'b101;
    localparam logic [2:0] SLL = 3'b100;
    localparam logic [2:0] BAD = 3'b010;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_data;
    logic [4:0]  req0_shamt;
    logic [2:0]  req0_op;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_data;
    logic [4:0]  req1_shamt;
    logic [2:0]  req1_op;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic        res_id, res_err;
    logic [31:0] sh_data;
    logic [4:0]  sh_sel;
    logic [2:0]  sh_signal;
    logic [31:0] sh_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Shared right shifter outside the arbiter
    assign sh_result = sh_data >> sh_sel;

    shift_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_data(req0_data), .req0_shamt(req0_shamt), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_data(req1_data), .req1_shamt(req1_shamt), .req1_op(req1_op),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .res_err(res_err),
        .sh_data(sh_data), .sh_sel(sh_sel), .sh_signal(sh_signal),
        .sh_result(sh_result)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model
    logic        m_full, m_last, m_id, m_err;
    logic [31:0] m_data;
    logic        e_rdy0, e_rdy1;

    always_comb begin
        e_rdy0 = !rst && (!m_full || res_ready) && req0_valid
                 && (!req1_valid || m_last);
        e_rdy1 = !rst && (!m_full || res_ready) && req1_valid
                 && (!req0_valid || !m_last);
    end

    function automatic logic [32:0] model_op(input logic [31:0] d,
                                             input logic [4:0] s,
                                             input logic [2:0] o);
        if (o == SRL) return {1'b0, d >> s};
        if (o == SLL) return {1'b0, d << s};
        return {1'b1, d};
    endfunction

    always @(posedge clk) begin
        logic [32:0] r;
        if (rst) begin
            m_full = 1'b0;
            m_last = 1'b1;
            m_data = '0;
            m_id   = 1'b0;
            m_err  = 1'b0;
        end else if (e_rdy0 || e_rdy1) begin
            r = e_rdy1 ? model_op(req1_data, req1_shamt, req1_op)
                       : model_op(req0_data, req0_shamt, req0_op);
            m_full = 1'b1;
            m_last = e_rdy1;
            m_id   = e_rdy1;
            m_data = r[31:0];
            m_err  = r[32];
        end else if (res_ready) begin
            m_full = 1'b0;
        end
    end

    always @(negedge clk) begin
        check("req0_ready", 32'(req0_ready), 32'(e_rdy0));
        check("req1_ready", 32'(req1_ready), 32'(e_rdy1));
        check("res_valid", 32'(res_valid), 32'(m_full));
        check("sh_signal", 32'(sh_signal), 32'(SRL));
        if (m_full) begin
            check("res_data", res_data, m_data);
            check("res_id", 32'(res_id), 32'(m_id));
            check("res_err", 32'(res_err), 32'(m_err));
        end
    end

    task automatic cyc(input logic v0, input logic [31:0] d0,
                       input logic [4:0] s0, input logic [2:0] o0,
                       input logic v1, input logic [31:0] d1,
                       input logic [4:0] s1, input logic [2:0] o1,
                       input logic rr);
        req0_valid = v0; req0_data = d0; req0_shamt = s0; req0_op = o0;
        req1_valid = v1; req1_data = d1; req1_shamt = s1; req1_op = o1;
        res_ready  = rr;
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic [31:0] d,
                       input logic id, input logic err);
        check({name, "_valid"}, 32'(res_valid), 32'd1);
        check({name, "_data"}, res_data, d);
        check({name, "_id"}, 32'(res_id), 32'(id));
        check({name, "_err"}, 32'(res_err), 32'(err));
    endtask

    logic [31:0] hold;

    initial begin
        rst = 1'b1;
        req0_valid = 0; req0_data = 0; req0_shamt = 0; req0_op = SRL;
        req1_valid = 0; req1_data = 0; req1_shamt = 0; req1_op = SRL;
        res_ready = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_data", res_data, 32'd0);
        check("rst_id", 32'(res_id), 32'd0);
        check("rst_err", 32'(res_err), 32'd0);

        cyc(1, 32'h8000_0000, 4, SRL, 0, 0, 0, SRL, 1);
        lit("srl4", 32'h0800_0000, 0, 0);
        cyc(1, 32'hFFFF_FFFF, 31, SRL, 0, 0, 0, SRL, 1);
        lit("srl31", 32'h0000_0001, 0, 0);
        cyc(0, 0, 0, SRL, 1, 32'h0000_00F1, 8, SLL, 1);
        lit("sll8", 32'h0000_F100, 1, 0);
        cyc(0, 0, 0, SRL, 1, 32'h0000_00F1, 0, SLL, 1);
        lit("sll0", 32'h0000_00F1, 1, 0);
        cyc(0, 0, 0, SRL, 1, 32'h8000_0001, 31, SLL, 1);
        lit("sll31", 32'h8000_0000, 1, 0);

        for (int k = 0; k < 4; k++) begin
            cyc(1, 32'hF000_0000, 4, SRL, 1, 32'h0000_000F, 4, SLL, 1);
            if (k[0]) lit("rr1", 32'h0000_00F0, 1, 0);
            else      lit("rr0", 32'h0F00_0000, 0, 0);
        end

        hold = res_data;
        for (int k = 0; k < 5; k++) begin
            cyc(1, 32'h0000_0100, 8, SRL, 1, 32'h0000_0001, 1, SLL, 0);
            check("bp_rdy0", 32'(req0_ready), 32'd0);
            check("bp_rdy1", 32'(req1_ready), 32'd0);
            check("bp_hold", res_data, hold);
            check("bp_valid", 32'(res_valid), 32'd1);
        end
        cyc(1, 32'h0000_0100, 8, SRL, 1, 32'h0000_0001, 1, SLL, 1);
        lit("bp_drain", 32'h0000_0001, 0, 0);

        cyc(1, 32'h1234_5678, 3, BAD, 0, 0, 0, SRL, 1);
        lit("illegal", 32'h1234_5678, 0, 1);
        cyc(1, 32'h1234_5678, 4, SRL, 0, 0, 0, SRL, 1);
        lit("clr_err", 32'h0123_4567, 0, 0);

        cyc(0, 0, 0, SRL, 0, 0, 0, SRL, 0);
        lit("mid_hold", 32'h0123_4567, 0, 0);
        rst = 1'b1;
        cyc(1, 32'h0000_0010, 1, SRL, 1, 32'h0000_0010, 1, SLL, 1);
        check("rst_rdy0", 32'(req0_ready), 32'd0);
        check("rst_rdy1", 32'(req1_ready), 32'd0);
        check("rst_mid_valid", 32'(res_valid), 32'd0);
        rst = 1'b0;
        cyc(1, 32'h0000_0010, 1, SRL, 1, 32'h0000_0010, 1, SLL, 1);
        lit("post_rst", 32'h0000_0008, 0, 0);
        cyc(1, 32'h0000_0010, 1, SRL, 1, 32'h0000_0010, 1, SLL, 1);
        lit("post_rst2", 32'h0000_0020, 1, 0);

        cyc(0, 0, 0, SRL, 0, 0, 0, SRL, 1);
        cyc(0, 0, 0, SRL, 0, 0, 0, SRL, 1);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
